// File: rtl/audio_pkg.sv
// Shared definitions for the audio ADC receive path: default widths, FSM state codes
// and the packed stereo frame layout (left channel in the MSBs).
package audio_pkg;

  localparam int CH_WIDTH           = 16;
  localparam int DEFAULT_DATA_WIDTH = 2 * CH_WIDTH;

  localparam logic [1:0] ST_SYNC  = 2'd0;
  localparam logic [1:0] ST_LEFT  = 2'd1;
  localparam logic [1:0] ST_RIGHT = 2'd2;

  typedef struct packed {
    logic [CH_WIDTH-1:0] left;
    logic [CH_WIDTH-1:0] right;
  } frame_t;

endpackage

// File: rtl/audio_rx_fifo.sv
// Single-clock show-ahead frame FIFO; rdata holds the head word in a register so it
// only moves on a pop or on a write into an empty buffer.
module audio_rx_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 128
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     wr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     rd,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   usedw
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_next;
  logic [AW:0]      count;
  logic             wr_ok;
  logic             rd_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign usedw   = count;
  assign rd_next = rd_ptr + 1'b1;
  // A full buffer still accepts a write when the same cycle pops a word.
  assign wr_ok   = wr && (!full || rd);
  assign rd_ok   = rd && !empty;

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rdata  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_next;
      count <= count + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
      // Popping the last word leaves rdata at its old value unless a write refills it.
      if (rd_ok) begin
        if (count > (AW+1)'(1)) rdata <= mem[rd_next];
        else if (wr_ok)         rdata <= wdata;
      end else if (wr_ok && empty) begin
        rdata <= wdata;
      end
    end
  end

endmodule

// File: rtl/audio_adc_rx.sv
// Left-justified codec ADC receiver: oversamples bclk/adclrc/adcdat, assembles one
// {left,right} frame per adclrc period and queues it in a show-ahead FIFO.
module audio_adc_rx
  import audio_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int FIFO_DEPTH  = 128,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          read,
  output logic [DATA_WIDTH-1:0]         readdata,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   usedw,
  output logic                          overrun,
  input  logic                          clear,
  input  logic                          bclk,
  input  logic                          adclrc,
  input  logic                          adcdat
);

  localparam int CW = DATA_WIDTH / 2;

  logic [SYNC_STAGES-1:0] bclk_sync;
  logic [SYNC_STAGES-1:0] lrc_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic                   bclk_hist;
  logic                   lrc_now;
  logic                   dat_now;
  logic                   bclk_rise;
  logic                   lrc_last;
  logic                   lrc_chg;
  logic                   flush;

  logic [1:0]             state;
  logic [CW-1:0]          shift_reg;
  logic [CW-1:0]          bit_mask;
  logic [CW-1:0]          left_hold;
  logic                   push;
  logic [DATA_WIDTH-1:0]  push_data;
  logic                   fifo_full;

  assign flush     = reset || clear;
  assign lrc_now   = lrc_sync[SYNC_STAGES-1];
  assign dat_now   = dat_sync[SYNC_STAGES-1];
  assign bclk_rise = bclk_sync[SYNC_STAGES-1] && !bclk_hist;
  assign lrc_chg   = (lrc_now != lrc_last);

  always_ff @(posedge clk) begin
    if (flush) begin
      bclk_sync <= '0;
      lrc_sync  <= '0;
      dat_sync  <= '0;
      bclk_hist <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], bclk};
      lrc_sync  <= {lrc_sync[SYNC_STAGES-2:0], adclrc};
      dat_sync  <= {dat_sync[SYNC_STAGES-2:0], adcdat};
      bclk_hist <= bclk_sync[SYNC_STAGES-1];
    end
  end

  // bit_mask marks the next half-word position to fill; once it shifts out, extra bits
  // are ignored, and a short channel simply leaves its low bits at zero.
  always_ff @(posedge clk) begin
    if (flush) begin
      state     <= ST_SYNC;
      lrc_last  <= 1'b0;
      shift_reg <= '0;
      bit_mask  <= '0;
      left_hold <= '0;
      push      <= 1'b0;
      push_data <= '0;
    end else begin
      push <= 1'b0;
      if (bclk_rise) begin
        lrc_last <= lrc_now;
        if (lrc_chg) begin
          shift_reg <= CW'(dat_now) << (CW - 1);
          bit_mask  <= CW'(1) << (CW - 2);
          case (state)
            ST_SYNC: begin
              if (!lrc_now) state <= ST_LEFT;
            end
            ST_LEFT: begin
              if (lrc_now) begin
                left_hold <= shift_reg;
                state     <= ST_RIGHT;
              end
            end
            ST_RIGHT: begin
              if (!lrc_now) begin
                push      <= 1'b1;
                push_data <= {left_hold, shift_reg};
                state     <= ST_LEFT;
              end
            end
            default: state <= ST_SYNC;
          endcase
        end else begin
          shift_reg <= shift_reg | (dat_now ? bit_mask : '0);
          bit_mask  <= bit_mask >> 1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (flush)                               overrun <= 1'b0;
    else if (push && fifo_full && !read)     overrun <= 1'b1;
  end

  audio_rx_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .wr    (push),
    .wdata (push_data),
    .rd    (read),
    .rdata (readdata),
    .full  (fifo_full),
    .empty (empty),
    .usedw (usedw)
  );

endmodule

// File: tb/tb_audio_adc_rx.sv
// Directed and randomised frames driven as a left-justified codec stream, checked
// against a queue-based frame model with one-frame-behind push semantics.
module tb_audio_adc_rx;
  import audio_pkg::*;

  localparam int DW    = 32;
  localparam int CH    = 16;
  localparam int DEPTH = 128;
  localparam int SS    = 2;

  logic                     clk = 1'b0;
  logic                     reset, clear, read, bclk, adclrc, adcdat;
  logic [DW-1:0]            readdata;
  logic                     empty, overrun;
  logic [$clog2(DEPTH):0]   usedw;

  always #5 clk = ~clk;

  audio_adc_rx #(
    .DATA_WIDTH  (DW),
    .FIFO_DEPTH  (DEPTH),
    .SYNC_STAGES (SS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .read     (read),
    .readdata (readdata),
    .empty    (empty),
    .usedw    (usedw),
    .overrun  (overrun),
    .clear    (clear),
    .bclk     (bclk),
    .adclrc   (adclrc),
    .adcdat   (adcdat)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Frame model: a frame exists only after a high->low adclrc edge, and is queued when
  // the following right->left edge arrives.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_rd;
  logic          m_ovr;
  int            m_phase;
  logic          m_prev;
  logic [CH-1:0] m_left, m_right;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic model_flush();
    q.delete();
    m_rd    = '0;
    m_ovr   = 1'b0;
    m_phase = 0;
  endtask

  task automatic model_push(input logic [DW-1:0] w, input logic rd);
    if (rd && q.size() > 0) void'(q.pop_front());
    if (q.size() < DEPTH) q.push_back(w);
    else                  m_ovr = 1'b1;
    if (q.size() > 0) m_rd = q[0];
  endtask

  task automatic do_reset(input logic use_clear);
    bclk = 1'b0;
    tick(SS + 2);
    if (use_clear) clear = 1'b1;
    else           reset = 1'b1;
    tick(2);
    clear = 1'b0;
    reset = 1'b0;
    model_flush();
  endtask

  task automatic send_bit(input logic lvl, input logic dat, input int half, input logic rd_at_push);
    int hi;
    bclk   = 1'b0;
    adclrc = lvl;
    adcdat = dat;
    tick(half);
    bclk = 1'b1;
    hi = (rd_at_push && half < SS + 2) ? SS + 2 : half;
    for (int c = 1; c <= hi; c++) begin
      @(posedge clk);
      #1;
      read = rd_at_push && (c == SS + 1);
    end
  endtask

  task automatic send_channel(input logic lvl, input logic [CH-1:0] val, input int nbits,
                              input int half, input logic rd_first);
    logic [31:0]   m32;
    logic [CH-1:0] expv;
    frame_t        f;
    logic          b;
    if (!lvl && m_prev) begin
      if (m_phase == 2) begin
        f.left  = m_left;
        f.right = m_right;
        model_push(f, rd_first);
      end
      m_phase = 1;
    end else if (lvl && !m_prev && m_phase == 1) begin
      m_phase = 2;
    end
    m32  = 32'hFFFF_FFFF << ((nbits >= CH) ? 0 : CH - nbits);
    expv = val & m32[CH-1:0];
    if (lvl) m_right = expv;
    else     m_left  = expv;
    m_prev = lvl;
    for (int i = 0; i < nbits; i++) begin
      b = (i < CH) ? val[CH-1-i] : logic'($urandom_range(1, 0));
      send_bit(lvl, b, half, rd_first && (i == 0));
    end
  endtask

  task automatic send_frame(input logic [CH-1:0] l, input logic [CH-1:0] r, input int nbits, input int half);
    send_channel(1'b0, l, nbits, half, 1'b0);
    send_channel(1'b1, r, nbits, half, 1'b0);
  endtask

  task automatic prime(input int half);
    send_channel(1'b1, 16'h0, 2, half, 1'b0);
  endtask

  task automatic close(input int half, input logic rd_first);
    send_channel(1'b0, 16'h0, 1, half, rd_first);
    tick(10);
  endtask

  task automatic drain(input string tag);
    int n;
    n = q.size();
    for (int i = 0; i < n; i++) begin
      check(tag, readdata, q[0]);
      read = 1'b1;
      tick(1);
      read = 1'b0;
      void'(q.pop_front());
      if (q.size() > 0) m_rd = q[0];
    end
    check({tag, "_empty"}, empty, 1'b1);
  endtask

  initial begin
    logic [CH-1:0] l, r;
    reset = 1'b1; clear = 1'b0; read = 1'b0;
    bclk = 1'b0; adclrc = 1'b0; adcdat = 1'b0;
    m_prev = 1'b0;
    model_flush();
    tick(4);
    reset = 1'b0;
    tick(1);
    check("rst_empty",    empty,    1'b1);
    check("rst_usedw",    usedw,    '0);
    check("rst_readdata", readdata, '0);
    check("rst_overrun",  overrun,  1'b0);

    // Single frame at bclk = clk/8
    do_reset(1'b0);
    prime(4);
    send_frame(16'hA5C3, 16'h5A3C, 16, 4);
    close(4, 1'b0);
    check("t1_readdata", readdata, 32'hA5C35A3C);
    check("t1_model",    readdata, m_rd);
    check("t1_usedw",    usedw,    1);
    check("t1_notempty", empty,    1'b0);
    drain("t1_read");
    check("t1_usedw0", usedw, 0);

    // Reset in the middle of the right channel
    do_reset(1'b0);
    prime(4);
    send_frame(16'h1111, 16'h2222, 16, 3);
    send_channel(1'b0, 16'h3333, 16, 3, 1'b0);
    send_channel(1'b1, 16'h4444, 8, 3, 1'b0);
    do_reset(1'b0);
    send_channel(1'b1, 16'h5555, 8, 3, 1'b0);
    check("t2_partial", usedw, 0);
    send_frame(16'hBEEF, 16'hCAFE, 16, 3);
    close(3, 1'b0);
    check("t2_usedw",    usedw,    1);
    check("t2_readdata", readdata, 32'hBEEFCAFE);
    drain("t2_read");

    // Short channels, left-justified with zero LSBs
    do_reset(1'b0);
    prime(2);
    send_frame(16'hFFFF, 16'hFFFF, 12, 2);
    close(2, 1'b0);
    check("t3_readdata", readdata, 32'hFFF0FFF0);
    check("t3_model",    readdata, m_rd);
    drain("t3_read");

    // Random values, lengths (including overlong channels) and bclk rates
    do_reset(1'b1);
    prime(3);
    for (int i = 0; i < 8; i++) begin
      l = CH'($urandom);
      r = CH'($urandom);
      send_frame(l, r, int'($urandom_range(20, 10)), int'($urandom_range(4, 2)));
    end
    close(2, 1'b0);
    check("rnd_usedw", usedw, DW'(q.size()));
    drain("rnd_word");

    // Overflow drops the newest frame; clear resets everything
    do_reset(1'b1);
    prime(2);
    for (int i = 0; i < DEPTH + 1; i++) send_frame(CH'($urandom), CH'($urandom), 16, 2);
    close(2, 1'b0);
    check("t4_usedw",    usedw,    DEPTH);
    check("t4_overrun",  overrun,  1'b1);
    check("t4_model_ov", overrun,  m_ovr);
    check("t4_head",     readdata, m_rd);
    do_reset(1'b1);
    check("t4_clr_empty",   empty,    1'b1);
    check("t4_clr_overrun", overrun,  1'b0);
    check("t4_clr_usedw",   usedw,    0);
    check("t4_clr_rdata",   readdata, '0);

    // Full FIFO with a read on the push cycle keeps both and preserves order
    prime(2);
    for (int i = 0; i < DEPTH + 1; i++) send_frame(CH'($urandom), CH'($urandom), 16, 2);
    tick(10);
    check("t5_full",     usedw,    DEPTH);
    check("t5_head_pre", readdata, m_rd);
    close(2, 1'b1);
    check("t5_usedw",   usedw,   DEPTH);
    check("t5_overrun", overrun, 1'b0);
    drain("t5_order");

    // Reads on an empty FIFO have no effect
    read = 1'b1;
    tick(10);
    read = 1'b0;
    tick(1);
    check("t6_usedw",    usedw,    0);
    check("t6_empty",    empty,    1'b1);
    check("t6_readdata", readdata, m_rd);
    check("t6_overrun",  overrun,  m_ovr);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
